dbg_bus_bridge: RTL and testbench

Debug bus bridge: a second initiator for the SoC peripheral bus, driven by a byte stream from a host (normally the UART receive/transmit byte interface). It parses read/write command frames, performs single 32-bit accesses on the memory-mapped peripheral/RAM bus, and returns the result bytes. It sits beside the RV32 core and shares the core's bus signalling. Bus arbitration between the core and this bridge lives outside the block.

---
 rtl/dbg_bus_bridge_if.sv | 28 ++
 rtl/dbg_bus_bridge.sv | 186 ++++++++++++++++++
 tb/tb_dbg_bus_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_bus_bridge_if.sv
// dbg_bus_bridge_if: host byte stream plus peripheral bus signals of the debug bridge.
interface dbg_bus_bridge_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_wen;
    logic        o_ren;
    logic        i_wready;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        o_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_wready, i_rdata, i_rvalid,
        output o_rx_ready, o_tx_data, o_tx_valid, o_addr, o_wdata, o_wstrb, o_wen, o_ren, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_wready, i_rdata, i_rvalid,
        input  o_rx_ready, o_tx_data, o_tx_valid, o_addr, o_wdata, o_wstrb, o_wen, o_ren, o_busy
    );
endinterface

// File: rtl/dbg_bus_bridge.sv
// dbg_bus_bridge: byte-stream command parser issuing single 32-bit bus reads/writes.
// Define DBG_BRIDGE_CKSUM_EN for XOR checksum bytes on command and response frames.
module dbg_bus_bridge #(
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rstn,
    dbg_bus_bridge_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
`ifdef DBG_BRIDGE_CKSUM_EN
        CKSUM,
`endif
        BUS_WR,
        BUS_RD,
        RESP
    } state_t;

`ifdef DBG_BRIDGE_CKSUM_EN
    localparam logic [2:0] RL1 = 3'd2;
    localparam logic [2:0] RL4 = 3'd5;
`else
    localparam logic [2:0] RL1 = 3'd1;
    localparam logic [2:0] RL4 = 3'd4;
`endif
    localparam logic [15:0] TO1 = 16'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic        op_wr;
    logic [15:0] tcnt;
    logic [39:0] resp;
    logic [2:0]  left;
`ifdef DBG_BRIDGE_CKSUM_EN
    logic [7:0]  rx_x;
`endif

    logic       rx_fire;
    logic [7:0] d;
    assign rx_fire       = bus.i_rx_valid & bus.o_rx_ready;
    assign d             = bus.i_rx_data;
    assign bus.o_tx_data = resp[39:32];

    // Response buffer is left-aligned; the top byte is the one on the wire.
    function automatic logic [39:0] one(input logic [7:0] c);
`ifdef DBG_BRIDGE_CKSUM_EN
        return {c, c, 24'h0};
`else
        return {c, 32'h0};
`endif
    endfunction

    function automatic logic [39:0] four(input logic [31:0] v);
`ifdef DBG_BRIDGE_CKSUM_EN
        return {v, v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0]};
`else
        return {v, 8'h0};
`endif
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            op_wr          <= 1'b0;
            tcnt           <= '0;
            resp           <= '0;
            left           <= '0;
`ifdef DBG_BRIDGE_CKSUM_EN
            rx_x           <= '0;
`endif
            bus.o_rx_ready <= 1'b1;
            bus.o_tx_valid <= 1'b0;
            bus.o_addr     <= '0;
            bus.o_wdata    <= '0;
            bus.o_wstrb    <= '0;
            bus.o_wen      <= 1'b0;
            bus.o_ren      <= 1'b0;
            bus.o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rx_fire) begin
                    bus.o_busy <= 1'b1;
                    cnt        <= '0;
                    op_wr      <= d == 8'h57;
`ifdef DBG_BRIDGE_CKSUM_EN
                    rx_x       <= d;
`endif
                    if (d == 8'h57 || d == 8'h52) begin
                        state <= ADDR;
                    end else begin
                        resp           <= one(8'h3F);
                        left           <= RL1;
                        bus.o_tx_valid <= 1'b1;
                        bus.o_rx_ready <= 1'b0;
                        state          <= RESP;
                    end
                end
                ADDR: if (rx_fire) begin
                    bus.o_addr <= {bus.o_addr[23:0], d};
                    cnt        <= cnt + 2'd1;
`ifdef DBG_BRIDGE_CKSUM_EN
                    rx_x       <= rx_x ^ d;
                    if (cnt == 2'd3) state <= op_wr ? DATA : CKSUM;
`else
                    if (cnt == 2'd3 && op_wr) state <= DATA;
                    if (cnt == 2'd3 && !op_wr) begin
                        bus.o_rx_ready <= 1'b0;
                        bus.o_ren      <= 1'b1;
                        tcnt           <= '0;
                        state          <= BUS_RD;
                    end
`endif
                end
                DATA: if (rx_fire) begin
                    bus.o_wdata <= {bus.o_wdata[23:0], d};
                    cnt         <= cnt + 2'd1;
`ifdef DBG_BRIDGE_CKSUM_EN
                    rx_x        <= rx_x ^ d;
                    if (cnt == 2'd3) state <= CKSUM;
`else
                    if (cnt == 2'd3) begin
                        bus.o_rx_ready <= 1'b0;
                        bus.o_wen      <= 1'b1;
                        bus.o_wstrb    <= 4'hF;
                        tcnt           <= '0;
                        state          <= BUS_WR;
                    end
`endif
                end
`ifdef DBG_BRIDGE_CKSUM_EN
                CKSUM: if (rx_fire) begin
                    bus.o_rx_ready <= 1'b0;
                    tcnt           <= '0;
                    if (d == rx_x) begin
                        bus.o_wen   <= op_wr;
                        bus.o_ren   <= !op_wr;
                        bus.o_wstrb <= {4{op_wr}};
                        state       <= op_wr ? BUS_WR : BUS_RD;
                    end else begin
                        resp           <= one(8'h45);
                        left           <= RL1;
                        bus.o_tx_valid <= 1'b1;
                        state          <= RESP;
                    end
                end
`endif
                // Handshake takes priority over a coincident timeout.
                BUS_WR: if (bus.i_wready || tcnt == TO1) begin
                    bus.o_wen      <= 1'b0;
                    bus.o_wstrb    <= '0;
                    resp           <= one(bus.i_wready ? 8'h4B : 8'h54);
                    left           <= RL1;
                    bus.o_tx_valid <= 1'b1;
                    state          <= RESP;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
                BUS_RD: if (bus.i_rvalid || tcnt == TO1) begin
                    bus.o_ren      <= 1'b0;
                    resp           <= bus.i_rvalid ? four(bus.i_rdata) : one(8'h54);
                    left           <= bus.i_rvalid ? RL4 : RL1;
                    bus.o_tx_valid <= 1'b1;
                    state          <= RESP;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
                RESP: if (bus.i_tx_ready) begin
                    if (left == 3'd1) begin
                        bus.o_tx_valid <= 1'b0;
                        bus.o_rx_ready <= 1'b1;
                        bus.o_busy     <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        resp <= {resp[31:0], 8'h0};
                        left <= left - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_bus_bridge.sv
// tb_dbg_bus_bridge: scoreboard bench for the debug bus bridge with a responsive bus model.
module tb_dbg_bus_bridge;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dbg_bus_bridge_if bus ();
    dbg_bus_bridge #(.TIMEOUT(255)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    int w_wait = 0, r_wait = 0, wcnt = 0, rcnt = 0, w_len = 0, r_len = 0, strobes = 0;
    logic [31:0] seen_addr = '0, seen_wdata = '0;
    logic [3:0] seen_wstrb = '0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // Bus model: handshake after a programmed number of strobe cycles, record strobe widths.
    always @(negedge clk) begin
        if (bus.o_wen) begin
            wcnt++;
            strobes++;
            seen_addr    = bus.o_addr;
            seen_wdata   = bus.o_wdata;
            seen_wstrb   = bus.o_wstrb;
            bus.i_wready = wcnt > w_wait;
        end else begin
            if (wcnt > 0) w_len = wcnt;
            wcnt = 0;
            bus.i_wready = 1'b0;
        end
        if (bus.o_ren) begin
            rcnt++;
            strobes++;
            seen_addr    = bus.o_addr;
            bus.i_rvalid = rcnt > r_wait;
        end else begin
            if (rcnt > 0) r_len = rcnt;
            rcnt = 0;
            bus.i_rvalid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.o_tx_valid && bus.i_tx_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_extra: got %h want none", bus.o_tx_data);
            end else begin
                chk("resp", {24'h0, bus.o_tx_data}, {24'h0, q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        while (!bus.o_rx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: got 0 want 1");
        end
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] w, input logic wr);
        logic [7:0] x;
        logic [7:0] b;
        x = op;
        send(op);
        for (int i = 0; i < 4; i++) begin
            b = a[31-8*i -: 8];
            x ^= b;
            send(b);
        end
        if (wr) for (int i = 0; i < 4; i++) begin
            b = w[31-8*i -: 8];
            x ^= b;
            send(b);
        end
`ifdef DBG_BRIDGE_CKSUM_EN
        send(x);
`endif
    endtask

    task automatic push1(input logic [7:0] c);
        q.push_back(c);
`ifdef DBG_BRIDGE_CKSUM_EN
        q.push_back(c);
`endif
    endtask

    task automatic push4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) q.push_back(v[31-8*i -: 8]);
`ifdef DBG_BRIDGE_CKSUM_EN
        q.push_back(v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0]);
`endif
    endtask

    task automatic wait_done(input string n);
        int k = 0;
        while ((bus.o_busy || q.size() != 0) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        chk(n, {31'h0, k < 3000}, 32'h1);
    endtask

    initial begin
        int s0;
        int k;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b1;
        bus.i_rdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", {31'h0, bus.o_rx_ready}, 32'h1);
        chk("rst_tx_valid", {31'h0, bus.o_tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, bus.o_tx_data}, 32'h0);
        chk("rst_wen", {31'h0, bus.o_wen}, 32'h0);
        chk("rst_ren", {31'h0, bus.o_ren}, 32'h0);
        chk("rst_wstrb", {28'h0, bus.o_wstrb}, 32'h0);
        chk("rst_addr", bus.o_addr, 32'h0);
        chk("rst_wdata", bus.o_wdata, 32'h0);
        chk("rst_busy", {31'h0, bus.o_busy}, 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;

        w_wait = 2;
        push1(8'h4B);
        frame(8'h57, 32'h2000_0000, 32'h0000_000F, 1'b1);
        wait_done("wr_done");
        chk("wr_wen_len", w_len, 3);
        chk("wr_addr", seen_addr, 32'h2000_0000);
        chk("wr_wdata", seen_wdata, 32'h0000_000F);
        chk("wr_wstrb", {28'h0, seen_wstrb}, 32'hF);

        r_wait = 1;
        bus.i_rdata = 32'hDEAD_BEEF;
        push4(32'hDEAD_BEEF);
        frame(8'h52, 32'h1000_0004, 32'h0, 1'b0);
        wait_done("rd_done");
        chk("rd_ren_len", r_len, 2);
        chk("rd_addr", seen_addr, 32'h1000_0004);

        s0 = strobes;
        push1(8'h3F);
        send(8'h41);
        wait_done("unk_done");
        chk("unk_strobes", strobes, s0);
        chk("unk_busy", {31'h0, bus.o_busy}, 32'h0);

        r_wait = 100000;
        push1(8'h54);
        frame(8'h52, 32'h4000_0000, 32'h0, 1'b0);
        wait_done("to_done");
        chk("to_ren_len", r_len, 255);
        r_wait = 1;

        bus.i_tx_ready = 1'b0;
        push4(32'hDEAD_BEEF);
        frame(8'h52, 32'h1000_0004, 32'h0, 1'b0);
        k = 0;
        while (!bus.o_tx_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_data", {24'h0, bus.o_tx_data}, 32'hDE);
            chk("bp_valid", {31'h0, bus.o_tx_valid}, 32'h1);
            @(posedge clk); #1;
        end
        bus.i_tx_ready = 1'b1;
        wait_done("bp_done");

        send(8'h52);
        send(8'h10);
        send(8'h00);
        rstn = 1'b0;
        #1;
        chk("mid_rx_ready", {31'h0, bus.o_rx_ready}, 32'h1);
        chk("mid_busy", {31'h0, bus.o_busy}, 32'h0);
        chk("mid_addr", bus.o_addr, 32'h0);
        chk("mid_strobe", {30'h0, bus.o_wen, bus.o_ren}, 32'h0);
        chk("mid_tx_valid", {31'h0, bus.o_tx_valid}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        r_wait = 0;
        bus.i_rdata = 32'h1234_5678;
        push4(32'h1234_5678);
        frame(8'h52, 32'h3000_0008, 32'h0, 1'b0);
        wait_done("post_rst_done");
        chk("post_rst_addr", seen_addr, 32'h3000_0008);
        chk("post_rst_ren_len", r_len, 1);

`ifdef DBG_BRIDGE_CKSUM_EN
        bus.i_rdata = 32'hCAFE_F00D;
        push4(32'hCAFE_F00D);
        send(8'h52); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h52);
        wait_done("ck_ok_done");
        s0 = strobes;
        q.push_back(8'h45);
        q.push_back(8'h45);
        send(8'h52); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h53);
        wait_done("ck_bad_done");
        chk("ck_bad_strobes", strobes, s0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
